// File: rtl/grid_stream_loader.sv
// grid_stream_loader: parses an ASCII '@'/'.' byte stream into a DEPTH x WIDTH bit grid.
// Define GRID_LOADER_CRLF_EN to accept and ignore 0x0D (Windows line endings).
module grid_stream_loader #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic [DEPTH*WIDTH-1:0] grid_out,
    output logic                   grid_valid,
    input  logic                   grid_ack,
    output logic [31:0]            roll_count,
    output logic                   err
);

    localparam int NB = DEPTH * WIDTH;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          r_state;
    logic [NB-1:0]   r_grid;
    logic [31:0]     r_count;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;

    state_t          w_state_nxt;
    logic [NB-1:0]   w_grid_nxt;
    logic [31:0]     w_count_nxt;
    logic [RW-1:0]   w_row_nxt;
    logic [CW-1:0]   w_col_nxt;
    logic            w_done;
    logic            w_bad;
    logic            w_beat;
    logic [IW-1:0]   w_idx;

    assign s_ready    = rst_n && (r_state != ST_HOLD);
    assign w_beat     = s_valid && s_ready;
    assign grid_valid = (r_state == ST_HOLD);
    assign err        = (r_state == ST_ERR);
    assign grid_out   = r_grid;
    assign roll_count = r_count;
    assign w_idx      = IW'(32'(r_row) * WIDTH + 32'(r_col));

    always_comb begin
        w_state_nxt = r_state;
        w_grid_nxt  = r_grid;
        w_count_nxt = r_count;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_done      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_beat) begin
                    case (s_data)
                        8'h40, 8'h2E: begin
                            if (r_col == COL_FULL) begin
                                w_bad = 1'b1;
                            end else begin
                                w_grid_nxt[w_idx] = (s_data == 8'h40);
                                if (s_data == 8'h40)
                                    w_count_nxt = r_count + 32'd1;
                                w_col_nxt = r_col + CW'(1);
                                if (r_row == ROW_LAST && r_col == COL_LAST)
                                    w_done = 1'b1;
                            end
                        end
                        8'h0A: begin
                            if (r_col == COL_FULL) begin
                                w_row_nxt = r_row + RW'(1);
                                w_col_nxt = '0;
                                if (r_row == ROW_LAST)
                                    w_done = 1'b1;
                            end else if (r_col != '0) begin
                                w_bad = 1'b1;
                            end
                        end
`ifdef GRID_LOADER_CRLF_EN
                        8'h0D: begin
                        end
`endif
                        default: w_bad = 1'b1;
                    endcase
                    // A completing beat wins over a stray s_last or ack.
                    if (w_done)
                        w_state_nxt = ST_HOLD;
                    else if (w_bad || s_last)
                        w_state_nxt = ST_ERR;
                end
            end
            ST_HOLD, ST_ERR: begin
                if (grid_ack) begin
                    w_state_nxt = ST_LOAD;
                    w_grid_nxt  = '0;
                    w_count_nxt = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_grid  <= '0;
            r_count <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grid  <= w_grid_nxt;
            r_count <= w_count_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed bench for grid_stream_loader at WIDTH=4, DEPTH=3.
// Build with GRID_LOADER_CRLF_EN to exercise the CRLF branch.
module tb_grid_stream_loader;

    localparam int W = 4;
    localparam int D = 3;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic [D*W-1:0] grid_out;
    logic          grid_valid;
    logic          grid_ack;
    logic [31:0]   roll_count;
    logic          err;

    int total = 0;
    int bad   = 0;

    grid_stream_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .grid_out   (grid_out),
        .grid_valid (grid_valid),
        .grid_ack   (grid_ack),
        .roll_count (roll_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        s_data  = b;
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50)
            chk("rdy_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1)
                tick();
            send_byte(s[i], last && (i == s.len() - 1));
        end
    endtask

    task automatic ack();
        grid_ack = 1'b1;
        tick();
        grid_ack = 1'b0;
    endtask

    task automatic chk_grid(input string tag);
        chk({tag, "_valid"}, 32'(grid_valid), 32'd1);
        chk({tag, "_grid"},  32'(grid_out),   32'h96B);
        chk({tag, "_count"}, roll_count,      32'd7);
        chk({tag, "_err"},   32'(err),        32'd0);
        chk({tag, "_rdy"},   32'(s_ready),    32'd0);
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_valid"}, 32'(grid_valid), 32'd0);
        chk({tag, "_grid"},  32'(grid_out),   32'd0);
        chk({tag, "_count"}, roll_count,      32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
        chk({tag, "_rdy"},   32'(s_ready),    32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        grid_ack = 1'b0;
        repeat (3) tick();
        chk("rst_grid",  32'(grid_out),   32'd0);
        chk("rst_count", roll_count,      32'd0);
        chk("rst_valid", 32'(grid_valid), 32'd0);
        chk("rst_err",   32'(err),        32'd0);
        chk("rst_rdy",   32'(s_ready),    32'd0);
        rst_n = 1'b1;
        tick();
        chk_clear("idle");

        // Stream 1; its trailing '\n' is left pending while the grid is held.
        send_str("@@.@\n.@@.\n@..@", 1'b0, 1'b0);
        chk_grid("s1");
        s_data  = 8'h0A;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_grid", 32'(grid_out),   32'h96B);
            chk("hold_rdy",  32'(s_ready),    32'd0);
            chk("hold_vld",  32'(grid_valid), 32'd1);
        end
        s_valid = 1'b0;
        ack();
        chk_clear("ack1");
        send_byte(8'h0A, 1'b0);
        chk("blank_err", 32'(err), 32'd0);
        chk("blank_vld", 32'(grid_valid), 32'd0);

        // Same grid, no final newline, s_last on last '@', random gaps.
        send_str("@@.@\n.@@.\n@..@", 1'b1, 1'b1);
        chk_grid("s2");
        ack();
        chk_clear("ack2");

        // Short row.
        send_str("@@.", 1'b0, 1'b0);
        chk("short_pre", 32'(err), 32'd0);
        send_byte(8'h0A, 1'b0);
        chk("short_err", 32'(err), 32'd1);
        chk("short_vld", 32'(grid_valid), 32'd0);
        send_str("x@.\n", 1'b1, 1'b0);
        chk("drain_err", 32'(err), 32'd1);
        chk("drain_rdy", 32'(s_ready), 32'd1);
        chk("drain_cnt", roll_count, 32'd2);
        // A beat alongside ack in ERR is discarded.
        s_data   = 8'h40;
        s_valid  = 1'b1;
        grid_ack = 1'b1;
        tick();
        s_valid  = 1'b0;
        grid_ack = 1'b0;
        chk_clear("errack");
        send_str("@@.@\n.@@.\n@..@", 1'b1, 1'b0);
        chk_grid("s3");
        ack();

        // Illegal byte first.
        send_byte(8'h78, 1'b0);
        chk("xbyte_err", 32'(err), 32'd1);
        ack();
        chk_clear("ack_x");

        // Row overflow on the fifth '@'.
        send_str("@@@@", 1'b0, 1'b0);
        chk("ovf_pre", 32'(err), 32'd0);
        chk("ovf_cnt", roll_count, 32'd4);
        send_byte(8'h40, 1'b0);
        chk("ovf_err", 32'(err), 32'd1);
        ack();

        // Premature s_last on the second row's newline.
        send_str("@@.@\n.@@.", 1'b0, 1'b0);
        chk("last_pre", 32'(err), 32'd0);
        send_byte(8'h0A, 1'b1);
        chk("last_err", 32'(err), 32'd1);
        ack();
        chk_clear("ack_l");

        // Reset after six beats.
        send_str("@@.@\n.", 1'b0, 1'b0);
        chk("mid_cnt",  roll_count,     32'd3);
        chk("mid_grid", 32'(grid_out),  32'h00B);
        rst_n = 1'b0;
        #1;
        chk("arst_grid", 32'(grid_out), 32'd0);
        chk("arst_cnt",  roll_count,    32'd0);
        chk("arst_rdy",  32'(s_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_str("@@.@\n.@@.\n@..@", 1'b1, 1'b0);
        chk_grid("s4");
        ack();
        chk_clear("ack4");

`ifdef GRID_LOADER_CRLF_EN
        send_str("@@.@\r\n.@@.\r\n@..@", 1'b0, 1'b0);
        chk_grid("crlf");
        ack();
`else
        send_str("@@.@", 1'b0, 1'b0);
        chk("cr_pre", 32'(err), 32'd0);
        send_byte(8'h0D, 1'b0);
        chk("cr_err", 32'(err), 32'd1);
        ack();
`endif
        chk_clear("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
